gpio_event_capture: RTL and testbench
=====================================

Name: gpio_event_capture

Overview:
- Synthesizable replacement for hand-driven bench pulses on the board GPIO header (e.g. the push-button line).
- Synchronizes and debounces N_CH GPIO inputs, then detects rising edges and latches them as sticky event flags.
- Exposes levels and flags to the 16-bit CPU through a registered, clear-on-read port.
- Sits between the top-level gpio1 pins and the CPU I/O decode, beside the VGA path.

Parameters:
- N_CH, 16, number of input channels (1..16).
- SYNC_STAGES, 2, synchronizer flop depth (>=2).
- DB_CYCLES, 4, consecutive stable cycles needed to accept a new level. Use 4 in sim; about 500000 on the 50 MHz board.
- CNT_W, $clog2(DB_CYCLES+1), debounce counter width (derived; do not override).

Ports:
- clk  in  1  system clock
- rst  in  1  reset, asynchronous, active-high
- gpio_in  in  N_CH  raw asynchronous pin inputs
- db_level  out  N_CH  debounced level per channel
- rise_pulse  out  N_CH  one-cycle pulse on each accepted rising edge
- rd_en  in  1  read strobe, one cycle
- rd_sel  in  2  0=levels, 1=rise flags (clear-on-read), 2=fall flags, 3=reserved
- rd_data  out  16  registered read data, zero-extended above N_CH
- rd_valid  out  1  high the cycle after rd_en
- irq  out  1  OR of all rise flags

Behaviour:
- Reset (async, any time): clears synchronizers, counters, db_level, rise_pulse, flags, rd_data, rd_valid and irq to 0. An in-flight debounce count is discarded.
- Synchronizer: per-channel chain of SYNC_STAGES flops; s = last stage.
- Debounce counter, per channel:
  - If s == db_level: cnt <= 0.
  - Else if cnt == DB_CYCLES-1: db_level <= s, cnt <= 0 (accept).
  - Else: cnt <= cnt+1.
- Latency: a clean input step becomes db_level exactly SYNC_STAGES+DB_CYCLES clocks after the first edge that samples it. Any glitch shorter than DB_CYCLES synchronized cycles causes no change.
- rise_pulse[i] is registered and asserts on the same edge db_level[i] goes 0->1, for exactly one cycle.
- Rise flag[i] sets on rise_pulse[i] and holds until cleared by a read.
- Read port:
  - On rd_en, rd_data and rd_valid update at the next edge. rd_data is held between reads; rd_valid drops after one cycle.
  - sel 0 returns db_level.
  - sel 1 returns the flags, and every returned set bit clears on that same edge.
  - sel 2: see optional feature. Sel 3 returns 0.
- Simultaneous set and clear on the same bit: set wins. The new event is not in the current rd_data and remains for the next read, so no event is lost.
- A pin held high through reset deasserts to a valid rise event after the debounce latency. This is intended behaviour.
- irq is registered and follows the flags one cycle later.

Optional Feature:
- Macro GPIO_FALL_EVENT_EN.
- Defined:
  - A per-channel fall flag sets on db_level 1->0.
  - rd_sel 2 returns the fall flags with the same clear-on-read and set-wins rules.
  - irq also ORs in the fall flags.
- Undefined: no fall logic is synthesized and rd_sel 2 returns 0.

Decomposition:
- Package gpio_event_pkg holds:
  - RD_SEL_LEVEL=2'd0, RD_SEL_RISE=2'd1, RD_SEL_FALL=2'd2.
  - DATA_W=16.
- Sub-module gpio_debounce_ch covers one channel's synchronizer, counter, db_level and edge pulses. It is instantiated N_CH times in a generate loop.
- Flags and the read mux stay in the top module.

Test Plan (N_CH=16, SYNC_STAGES=2, DB_CYCLES=4):
1. Reset: pulse rst 10 ns with gpio_in=0 -> all outputs 0; a read at sel 0 returns 0x0000.
2. Clean press: gpio_in[9]=1 for 20 cycles -> db_level[9] rises 6 clocks after the first sampling edge; rise_pulse[9] is high 1 cycle; irq=1. Read sel 1 returns 0x0200, the next read returns 0x0000 and irq drops.
3. Glitch: gpio_in[3]=1 for 3 cycles, then 0 -> db_level, rise_pulse and flags stay 0.
4. Collision: issue a sel 1 read on the same edge rise_pulse[5] fires -> rd_data=0x0000, flag[5] stays set, next read returns 0x0020.
5. Reset mid-debounce: assert rst when channel 0 cnt=2, release, keep the input high -> the count restarts from 0 and db_level[0] rises 6 clocks after release.
6. Feature: 1->0 step on channel 7 -> with GPIO_FALL_EVENT_EN a sel 2 read returns 0x0080 and irq asserts; without it, sel 2 returns 0x0000.

Source files
------------

// File: rtl/gpio_event_pkg.sv
// Shared constants for the GPIO event capture block: read-select codes and
// the CPU data-bus width. The optional falling-edge event logic is enabled
// with the GPIO_FALL_EVENT_EN macro.
`timescale 1ns/1ps
package gpio_event_pkg;

   // CPU data bus width; channel data is zero-extended up to this width
   localparam int DATA_W = 16;

   // Read-select codes on rd_sel
   localparam logic [1:0] RD_SEL_LEVEL = 2'd0;
   localparam logic [1:0] RD_SEL_RISE  = 2'd1;
   localparam logic [1:0] RD_SEL_FALL  = 2'd2;
   localparam logic [1:0] RD_SEL_RSVD  = 2'd3;

   typedef logic [DATA_W-1:0] data_t;

endpackage : gpio_event_pkg

// File: rtl/gpio_debounce_ch.sv
// One GPIO channel: synchronizer chain, debounce counter, accepted level and
// registered edge pulses. The falling-edge pulse output only exists when
// GPIO_FALL_EVENT_EN is defined.
`timescale 1ns/1ps
module gpio_debounce_ch
   import gpio_event_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int CNT_W       = $clog2(DB_CYCLES + 1)
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic pin_i,
   output logic level_o,
   output logic rise_o
`ifdef GPIO_FALL_EVENT_EN
   ,
   output logic fall_o
`endif
);

   // Counter value on which a differing level has been stable long enough
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   sync_s;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   level_q, level_d;
   logic                   rise_q, rise_d;
`ifdef GPIO_FALL_EVENT_EN
   logic                   fall_q, fall_d;
`endif

   assign sync_s = sync_q[SYNC_STAGES-1];

   // Synchronizer chain: the raw pin enters at bit 0, the last stage is safe to use
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], pin_i};
      end
   end

   // Debounce decision: count consecutive cycles the synchronized input differs
   // from the accepted level, accept it once the run reaches DB_CYCLES
   always_comb begin
      cnt_d   = cnt_q;
      level_d = level_q;
      rise_d  = 1'b0;
`ifdef GPIO_FALL_EVENT_EN
      fall_d  = 1'b0;
`endif
      if (sync_s == level_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         level_d = sync_s;
         cnt_d   = '0;
         rise_d  = sync_s;
`ifdef GPIO_FALL_EVENT_EN
         fall_d  = ~sync_s;
`endif
      end else begin
         cnt_d = cnt_q + CNT_ONE;
      end
   end

   // Counter, accepted level and edge pulses; pulses land on the same edge as the level change
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         cnt_q   <= '0;
         level_q <= 1'b0;
         rise_q  <= 1'b0;
`ifdef GPIO_FALL_EVENT_EN
         fall_q  <= 1'b0;
`endif
      end else begin
         cnt_q   <= cnt_d;
         level_q <= level_d;
         rise_q  <= rise_d;
`ifdef GPIO_FALL_EVENT_EN
         fall_q  <= fall_d;
`endif
      end
   end

   assign level_o = level_q;
   assign rise_o  = rise_q;
`ifdef GPIO_FALL_EVENT_EN
   assign fall_o  = fall_q;
`endif

endmodule : gpio_debounce_ch

// File: rtl/gpio_event_capture.sv
// GPIO event capture: per-channel synchronize/debounce, sticky rise-event
// flags, registered clear-on-read CPU port and an interrupt line.
// Define GPIO_FALL_EVENT_EN to add sticky fall-event flags readable at
// rd_sel 2 and OR-ed into irq; otherwise rd_sel 2 reads as zero.
`timescale 1ns/1ps
module gpio_event_capture
   import gpio_event_pkg::*;
#(
   parameter int N_CH        = 16,
   parameter int SYNC_STAGES = 2,
   parameter int DB_CYCLES   = 4,
   parameter int CNT_W       = $clog2(DB_CYCLES + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   gpio_in,
   output logic [N_CH-1:0]   db_level,
   output logic [N_CH-1:0]   rise_pulse,
   input  logic              rd_en,
   input  logic [1:0]        rd_sel,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              irq
);

   logic [N_CH-1:0] rise_flag_q, rise_flag_d;
   logic            rd_rise;
   data_t           rd_data_q, rd_data_d;
   logic            rd_valid_q;
   logic            irq_q, irq_d;
`ifdef GPIO_FALL_EVENT_EN
   logic [N_CH-1:0] fall_pulse;
   logic [N_CH-1:0] fall_flag_q, fall_flag_d;
   logic            rd_fall;
`endif

   // One debounce channel per GPIO pin
   generate
      for (genvar gi = 0; gi < N_CH; gi++) begin : g_ch
         gpio_debounce_ch #(
            .SYNC_STAGES (SYNC_STAGES),
            .DB_CYCLES   (DB_CYCLES),
            .CNT_W       (CNT_W)
         ) u_ch (
            .clk_i   (clk),
            .rst_i   (rst),
            .pin_i   (gpio_in[gi]),
            .level_o (db_level[gi]),
            .rise_o  (rise_pulse[gi])
`ifdef GPIO_FALL_EVENT_EN
            ,
            .fall_o  (fall_pulse[gi])
`endif
         );
      end
   endgenerate

   assign rd_rise = rd_en && (rd_sel == RD_SEL_RISE);
`ifdef GPIO_FALL_EVENT_EN
   assign rd_fall = rd_en && (rd_sel == RD_SEL_FALL);
`endif

   // Sticky flags: a read clears every bit it returns, a new pulse on the same
   // edge still sets its bit so the event is reported by the following read
   always_comb begin
      rise_flag_d = (rd_rise ? '0 : rise_flag_q) | rise_pulse;
`ifdef GPIO_FALL_EVENT_EN
      fall_flag_d = (rd_fall ? '0 : fall_flag_q) | fall_pulse;
`endif
   end

   // Read mux: capture the selected word on a strobe, otherwise hold the last one
   always_comb begin
      rd_data_d = rd_data_q;
      if (rd_en) begin
         rd_data_d = '0;
         case (rd_sel)
            RD_SEL_LEVEL: rd_data_d[N_CH-1:0] = db_level;
            RD_SEL_RISE:  rd_data_d[N_CH-1:0] = rise_flag_q;
`ifdef GPIO_FALL_EVENT_EN
            RD_SEL_FALL:  rd_data_d[N_CH-1:0] = fall_flag_q;
`endif
            default:      rd_data_d = '0;
         endcase
      end
   end

   // Interrupt request follows the flag registers one cycle later
   always_comb begin
      irq_d = |rise_flag_q;
`ifdef GPIO_FALL_EVENT_EN
      irq_d = irq_d | (|fall_flag_q);
`endif
   end

   // Flag, read-port and interrupt registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rise_flag_q <= '0;
`ifdef GPIO_FALL_EVENT_EN
         fall_flag_q <= '0;
`endif
         rd_data_q   <= '0;
         rd_valid_q  <= 1'b0;
         irq_q       <= 1'b0;
      end else begin
         rise_flag_q <= rise_flag_d;
`ifdef GPIO_FALL_EVENT_EN
         fall_flag_q <= fall_flag_d;
`endif
         rd_data_q   <= rd_data_d;
         rd_valid_q  <= rd_en;
         irq_q       <= irq_d;
      end
   end

   assign rd_data  = rd_data_q;
   assign rd_valid = rd_valid_q;
   assign irq      = irq_q;

endmodule : gpio_event_capture

// File: tb/tb_gpio_event_capture.sv
// Self-checking bench for gpio_event_capture (N_CH=16, SYNC_STAGES=2,
// DB_CYCLES=4). Honours GPIO_FALL_EVENT_EN in the same way as the design.
`timescale 1ns/1ps
module tb_gpio_event_capture;

   localparam int N    = 16;
   localparam int SYNC = 2;
   localparam int DB   = 4;
   localparam int WIN  = SYNC + DB;
`ifdef GPIO_FALL_EVENT_EN
   localparam bit FALL_EN = 1'b1;
`else
   localparam bit FALL_EN = 1'b0;
`endif

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic [N-1:0]  gpio_in = '0;
   logic [N-1:0]  db_level;
   logic [N-1:0]  rise_pulse;
   logic          rd_en = 1'b0;
   logic [1:0]    rd_sel = 2'd0;
   logic [15:0]   rd_data;
   logic          rd_valid;
   logic          irq;

   int total = 0;
   int bad   = 0;
   bit cmp_en = 1'b0;

   gpio_event_capture #(
      .N_CH        (N),
      .SYNC_STAGES (SYNC),
      .DB_CYCLES   (DB)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .gpio_in    (gpio_in),
      .db_level   (db_level),
      .rise_pulse (rise_pulse),
      .rd_en      (rd_en),
      .rd_sel     (rd_sel),
      .rd_data    (rd_data),
      .rd_valid   (rd_valid),
      .irq        (irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: a pin level is accepted when the raw samples taken
   // SYNC..SYNC+DB-1 edges ago all disagree with the current accepted level.
   logic [N-1:0] samp [WIN];
   logic [N-1:0] m_lvl, m_rise, m_fall, m_rflag, m_fflag, m_acc;
   logic [15:0]  m_rd;
   logic         m_valid, m_irq;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < WIN; k++) samp[k] = '0;
         m_lvl = '0; m_rise = '0; m_fall = '0; m_rflag = '0; m_fflag = '0;
         m_rd = '0; m_valid = 1'b0; m_irq = 1'b0;
      end else begin
         for (int k = WIN - 1; k > 0; k--) samp[k] = samp[k-1];
         samp[0] = gpio_in;
         m_acc = '1;
         for (int k = SYNC; k < WIN; k++) m_acc = m_acc & (samp[k] ^ m_lvl);
         if (rd_en) begin
            case (rd_sel)
               2'd0:    m_rd = m_lvl;
               2'd1:    m_rd = m_rflag;
               2'd2:    m_rd = FALL_EN ? m_fflag : 16'h0;
               default: m_rd = 16'h0;
            endcase
         end
         m_valid = rd_en;
         m_irq   = (|m_rflag) | (FALL_EN & (|m_fflag));
         m_rflag = ((rd_en && rd_sel == 2'd1) ? 16'h0 : m_rflag) | m_rise;
         if (FALL_EN)
            m_fflag = ((rd_en && rd_sel == 2'd2) ? 16'h0 : m_fflag) | m_fall;
         m_rise = m_acc & ~m_lvl;
         m_fall = m_acc & m_lvl;
         m_lvl  = m_lvl ^ m_acc;
      end
   end

   // Cycle compare against the model, away from the active edge
   always @(negedge clk) begin
      if (cmp_en) begin
         check("cyc_db_level",   32'(db_level),   32'(m_lvl));
         check("cyc_rise_pulse", 32'(rise_pulse), 32'(m_rise));
         check("cyc_rd_data",    32'(rd_data),    32'(m_rd));
         check("cyc_rd_valid",   32'(rd_valid),   32'(m_valid));
         check("cyc_irq",        32'(irq),        32'(m_irq));
      end
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_read(input logic [1:0] sel, output logic [15:0] data);
      rd_en  = 1'b1;
      rd_sel = sel;
      @(negedge clk);
      rd_en  = 1'b0;
      data   = rd_data;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog simulation did not finish, actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [15:0] d;
      // 1. reset
      @(negedge clk);
      rst = 1'b0;
      cmp_en = 1'b1;
      check("t1_db_level", 32'(db_level), 0);
      check("t1_rise", 32'(rise_pulse), 0);
      check("t1_irq", 32'(irq), 0);
      check("t1_rd_valid", 32'(rd_valid), 0);
      do_read(2'd0, d);
      check("t1_read_lvl", 32'(d), 32'h0000);

      // 2. clean press on channel 9
      gpio_in[9] = 1'b1;
      tick(5);
      check("t2_lvl_before", 32'(db_level[9]), 0);
      tick(1);
      check("t2_lvl_at6", 32'(db_level[9]), 1);
      check("t2_rise_at6", 32'(rise_pulse), 32'h0200);
      tick(1);
      check("t2_rise_one", 32'(rise_pulse), 32'h0000);
      tick(13);
      check("t2_irq", 32'(irq), 1);
      gpio_in[9] = 1'b0;
      do_read(2'd1, d);
      check("t2_read_flag", 32'(d), 32'h0200);
      do_read(2'd1, d);
      check("t2_read_clear", 32'(d), 32'h0000);
      check("t2_irq_drop", 32'(irq), 0);

      // 3. glitch on channel 3
      tick(10);
      gpio_in[3] = 1'b1;
      tick(3);
      gpio_in[3] = 1'b0;
      tick(10);
      check("t3_lvl", 32'(db_level), 32'h0000);
      do_read(2'd1, d);
      check("t3_flags", 32'(d), 32'h0000);

      // 4. read collides with rise_pulse[5]
      gpio_in[5] = 1'b1;
      tick(6);
      check("t4_rise", 32'(rise_pulse), 32'h0020);
      rd_en = 1'b1;
      rd_sel = 2'd1;
      @(negedge clk);
      rd_en = 1'b0;
      check("t4_collide_data", 32'(rd_data), 32'h0000);
      tick(1);
      do_read(2'd1, d);
      check("t4_next_read", 32'(d), 32'h0020);

      // 5. reset mid-debounce on channel 0
      gpio_in[0] = 1'b1;
      tick(4);
      #2 rst = 1'b1;
      #2 rst = 1'b0;
      tick(5);
      check("t5_lvl_before", 32'(db_level[0]), 0);
      tick(1);
      check("t5_lvl_at6", 32'(db_level[0]), 1);
      tick(4);
      do_read(2'd0, d);
      check("t5_read_lvl", 32'(d), 32'h0021);
      do_read(2'd3, d);
      check("t5_read_rsvd", 32'(d), 32'h0000);

      // 6. falling edge on channel 7
      gpio_in[7] = 1'b1;
      tick(10);
      do_read(2'd1, d);
      check("t6_rise_flags", 32'(d), 32'h00A1);
      do_read(2'd2, d);
      check("t6_fall_empty", 32'(d), 32'h0000);
      tick(2);
      check("t6_irq_idle", 32'(irq), 0);
      gpio_in[7] = 1'b0;
      tick(10);
      check("t6_irq_fall", 32'(irq), 32'(FALL_EN));
      do_read(2'd2, d);
      check("t6_read_fall", 32'(d), FALL_EN ? 32'h0080 : 32'h0000);
      tick(3);

      cmp_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule : tb_gpio_event_capture
